// File: rtl/ld_cnt_pkg.sv
// ld_cnt_pkg: shared state and mode encodings for the loadable down-counter family
package ld_cnt_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
  localparam int M_WRAP    = 0;
  localparam int M_RELOAD  = 1;
  localparam int M_ONESHOT = 2;
endpackage

// File: rtl/ld_cnt_slice.sv
// ld_cnt_slice: counter register with decrement/underflow mux and borrow-out
module ld_cnt_slice #(
  parameter int WIDTH = 4
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             i_ld,
  input  logic             i_ce,
  input  logic             i_bi,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_uf_q,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero,
  output logic             o_bo
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] r_q;
  logic             w_zero;
  assign w_zero = (r_q == '0);
  always_ff @(posedge CK) begin
    if (CD) r_q <= '0;
    else if (i_ld) r_q <= i_d;
    else if (i_ce) r_q <= w_zero ? i_uf_q : r_q - ONE;
  end
  assign o_q    = r_q;
  assign o_zero = w_zero;
  assign o_bo   = i_bi & w_zero & i_run;
endmodule

// File: rtl/ld_down_counter.sv
// ld_down_counter: loadable cascadable down-counter with WRAP, RELOAD and ONESHOT behaviours
module ld_down_counter
  import ld_cnt_pkg::*;
#(
  parameter int    WIDTH = 4,
  parameter string MODE  = "WRAP"
) (
  input  logic             CK,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             SD,
  input  logic             SP,
  input  logic             BI,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC,
  output logic             DONE
);
  localparam int MODE_I = (MODE == "WRAP")    ? M_WRAP    :
                          (MODE == "RELOAD")  ? M_RELOAD  :
                          (MODE == "ONESHOT") ? M_ONESHOT : -1;
  if (MODE_I < 0 || WIDTH < 1 || WIDTH > 32) begin : g_bad
    $fatal(1, "ld_down_counter: illegal MODE or WIDTH");
  end
  state_t           r_state;
  logic [WIDTH-1:0] r_rld;
  logic             r_tc;
  logic             w_run;
  logic             w_ce;
  logic             w_uf;
  logic             w_zero;
  logic [WIDTH-1:0] w_uf_q;
  assign w_run  = (r_state == ST_RUN);
  assign w_ce   = SP & ~SD & BI & w_run;
  assign w_uf   = w_ce & w_zero;
  assign w_uf_q = (MODE_I == M_WRAP) ? '1 : (MODE_I == M_RELOAD) ? r_rld : '0;
  ld_cnt_slice #(.WIDTH(WIDTH)) u_slice (
    .CK     (CK),
    .CD     (CD),
    .i_ld   (SP & SD),
    .i_ce   (w_ce),
    .i_bi   (BI),
    .i_run  (w_run),
    .i_d    (D),
    .i_uf_q (w_uf_q),
    .o_q    (Q),
    .o_zero (w_zero),
    .o_bo   (BO)
  );
  // WRAP slices come out of reset already counting so a cascade needs no start load
  always_ff @(posedge CK) begin
    if (CD) begin
      r_rld   <= '0;
      r_tc    <= 1'b0;
      r_state <= (MODE_I == M_WRAP) ? ST_RUN : ST_IDLE;
    end else if (!SP) begin
      r_tc <= 1'b0;
    end else if (SD) begin
      r_rld   <= D;
      r_tc    <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_tc <= w_uf;
      if (w_uf && MODE_I == M_ONESHOT) r_state <= ST_DONE;
    end
  end
  assign TC   = r_tc;
  assign DONE = (r_state == ST_DONE);
endmodule

// File: doc/ld_down_counter.md
# ld_down_counter

Loadable, cascadable down-counter with borrow-in/borrow-out, clock enable and a registered terminal-count pulse. It is the decrementing counterpart to the loadable 4-bit up-counter cell family. Library users build timers, prescalers and wide down-counters from it, either as a single instance or as a borrow-chained cascade of slices. Three selectable behaviours:
- free-running wrap (cascade slice)
- auto-reload timer
- one-shot timer with a done state

## Interface
- WIDTH, 4: counter width in bits; legal range 1–32.
- MODE, "WRAP": one of "WRAP", "RELOAD", "ONESHOT".
- CK  input  1  clock; all state changes on its rising edge.
- CD  input  1  reset; synchronous, active-high.
- D  input  WIDTH  load value.
- SD  input  1  load select: 1 = load D, 0 = count.
- SP  input  1  clock enable; gates both load and count.
- BI  input  1  borrow in / count enable from the lower slice; tie to 1 on the lowest slice.
- Q  output  WIDTH  counter value.
- BO  output  1  borrow out, combinational; connect to BI of the next slice.
- TC  output  1  registered one-cycle underflow pulse.
- DONE  output  1  high while in state DONE; ONESHOT mode only, otherwise 0.

## Operation
- Reset values (CD=1 at an edge):
  - Q=0, reload register RLD=0, TC=0, DONE=0.
  - State = RUN for WRAP, IDLE for RELOAD/ONESHOT.
- Priority at each edge: CD > SP=0 (hold everything; TC clears) > SD=1 (load) > count.
- States:
  - IDLE: no counting; Q holds.
  - RUN: counting.
  - DONE: ONESHOT only; Q held at 0.
- Load (SP=1, SD=1), any state:
  - Q<=D, RLD<=D, state<=RUN.
  - A load never asserts TC.
- Count enable: CE = SP & ~SD & BI & (state==RUN).
- Underflow event: UF = CE & (Q==0).
- On CE with Q≠0: Q<=Q-1.
- On UF:
  - WRAP: Q<=2^WIDTH-1.
  - RELOAD: Q<=RLD. If RLD==0, Q stays 0 and UF recurs on every CE.
  - ONESHOT: Q stays 0, state<=DONE.
- TC<=UF on every enabled edge.
- BO = BI & (Q==0) & (state==RUN). BO is not gated by SP or SD. The cascade relies on a shared SP/SD.
- Arithmetic is modulo 2^WIDTH. RLD is only updated by a load.
- Cascade: slices share CK, CD, SP and SD, and chain BO to BI. The upper slice decrements exactly on the edge where the lower slice underflows.

## Timing
- Q updates 1 cycle after the qualifying edge; there is no pipeline.
- TC is high for exactly the cycle following the UF edge. Back-to-back UFs (RLD=0 in RELOAD) hold TC high continuously.
- DONE rises 1 cycle after the UF edge and falls 1 cycle after a load or CD.
- BO follows Q/BI/state combinationally within the same cycle.
- Simultaneous events:
  - Load and underflow condition on the same edge: load wins; TC=0.
  - CD mid-count: Q=0 on the next cycle, and any pending TC is suppressed.
- SP=0 freezes Q, RLD and state.

## Structure
- Shared package `ld_cnt_pkg`:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - mode constants.
- One sub-module: `ld_cnt_slice` holds the Q register, the decrement/wrap mux and the BO term. The top adds RLD, the FSM and TC/DONE.
- MODE is checked at elaboration: an illegal string or WIDTH outside 1–32 is a fatal error.

## Test plan
- WRAP, WIDTH=4, after reset:
  - SP=1, SD=0, BI=1 for 17 cycles.
  - Required: Q = 0, F, E, …, 1, 0, F; TC high in the cycle after each Q=0 edge; BO=1 exactly while Q=0.
- RELOAD, WIDTH=8:
  - Load 8'h03, then count.
  - Required: Q = 3, 2, 1, 0, 3, 2, …; TC pulses every 4 enabled cycles.
  - Then load 0: TC is continuously high while counting.
- ONESHOT, WIDTH=4:
  - Load 2, then count.
  - Required: Q = 2, 1, 0, then holds 0; DONE=1 from the cycle after UF; BO=0 in DONE.
  - Reload 5: DONE drops and counting resumes from 5.
- Cascade of two WIDTH=4 WRAP slices (BO0→BI1):
  - Load 8'h10.
  - Required: combined value {Q1,Q0} = 10, 0F, 0E, …, 00, FF; upper slice changes only on lower-slice underflow edges.
- Priority/boundaries:
  - SP=0 with SD=1: no load.
  - CD=1 together with a load: Q=0.
  - Load of 7 on the same edge as an underflow condition: Q=7, TC=0.
  - IDLE state (RELOAD mode) with SD=0, SP=1 for 10 cycles: Q stays 0, TC stays 0.
